// File: rtl/seq_mon_pkg.sv
// Shared types and the sequence-counter cycle table for seq_monitor.
// Optional history register is enabled with `define SEQ_MON_HIST_EN.
package seq_mon_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LOCKED = 2'd1,
    FAULT  = 2'd2
  } state_t;

  localparam logic [2:0] ILLEGAL_CODE = 3'b100;

  // Cycle 001->010->011->000->111->110->101->001; the unreachable 100 maps to 000.
  function automatic logic [2:0] seq_next(input logic [2:0] cur);
    logic [2:0] nxt;
    case (cur)
      3'b001:  nxt = 3'b010;
      3'b010:  nxt = 3'b011;
      3'b011:  nxt = 3'b000;
      3'b000:  nxt = 3'b111;
      3'b111:  nxt = 3'b110;
      3'b110:  nxt = 3'b101;
      3'b101:  nxt = 3'b001;
      default: nxt = 3'b000;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/seq_monitor_lut.sv
// Combinational lookup of the successor code in the monitored counter cycle.
// Used by seq_monitor (see SEQ_MON_HIST_EN in the top for the optional history).
module seq_next_lut
  import seq_mon_pkg::*;
(
  input  logic [2:0] cur,
  output logic [2:0] nxt
);

  assign nxt = seq_next(cur);

endmodule

// File: rtl/seq_monitor.sv
// Checks a 3-bit sequence counter against its fixed cycle, locks, counts laps and flags errors.
// Define SEQ_MON_HIST_EN to enable the 4-entry history of legal states on hist.
module seq_monitor
  import seq_mon_pkg::*;
#(
  parameter int         LAP_W  = 8,
  parameter int         LOCK_N = 3,
  parameter logic [2:0] START  = 3'b001
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [2:0]       q_in,
  input  logic             en,
  output logic             locked,
  output logic             err,
  output logic             err_sticky,
  output logic             lap_pulse,
  output logic [LAP_W-1:0] lap_cnt,
  output logic [2:0]       exp_next,
  output logic [11:0]      hist
);

  state_t     state;
  logic [2:0] prev;
  logic       prev_v;
  logic [2:0] match_cnt;
  logic [2:0] lut_next;
  logic       legal;
  logic       step_ok;
  logic       lap_full;

  seq_next_lut u_lut (
    .cur (prev),
    .nxt (lut_next)
  );

  // exp_next is a pure decode of the prev/prev_v flops, so it changes only at clock edges.
  assign exp_next = prev_v ? lut_next : 3'b000;

  // A prev of 100 has no legal successor even though its table entry is 000.
  assign legal    = prev_v && (q_in == lut_next) && (q_in != ILLEGAL_CODE)
                    && (prev != ILLEGAL_CODE);
  assign step_ok  = legal && (state != FAULT);
  assign lap_full = &lap_cnt;

  always_ff @(posedge clk) begin
    if (clear) begin
      state      <= SEARCH;
      prev       <= 3'b000;
      prev_v     <= 1'b0;
      match_cnt  <= 3'd0;
      locked     <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      lap_pulse  <= 1'b0;
      lap_cnt    <= '0;
    end else if (en) begin
      err       <= 1'b0;
      lap_pulse <= 1'b0;
      prev      <= q_in;
      prev_v    <= 1'b1;
      case (state)
        SEARCH: begin
          if (prev_v) begin
            if (legal) begin
              if (match_cnt == 3'(LOCK_N - 1)) begin
                state     <= LOCKED;
                locked    <= 1'b1;
                match_cnt <= 3'd0;
              end else begin
                match_cnt <= match_cnt + 3'd1;
              end
            end else begin
              match_cnt <= 3'd0;
            end
          end
        end
        LOCKED: begin
          if (legal) begin
            if ((q_in == START) && !lap_full) begin
              lap_cnt   <= lap_cnt + 1'b1;
              lap_pulse <= 1'b1;
            end
          end else begin
            state      <= FAULT;
            locked     <= 1'b0;
            err        <= 1'b1;
            err_sticky <= 1'b1;
          end
        end
        FAULT: begin
          // This sample only re-seeds prev; checking resumes on the next one.
          state     <= SEARCH;
          match_cnt <= 3'd0;
        end
        default: begin
          state     <= SEARCH;
          locked    <= 1'b0;
          match_cnt <= 3'd0;
        end
      endcase
    end else begin
      err       <= 1'b0;
      lap_pulse <= 1'b0;
    end
  end

`ifdef SEQ_MON_HIST_EN
  logic [11:0] hist_r;

  always_ff @(posedge clk) begin
    if (clear) begin
      hist_r <= 12'h000;
    end else if (en && step_ok) begin
      hist_r <= {hist_r[8:0], q_in};
    end
  end

  assign hist = hist_r;
`else
  logic unused_step;
  assign unused_step = step_ok;
  assign hist        = 12'h000;
`endif

endmodule
